// File: rtl/morse_line_switch.sv
`default_nettype none
// ============================================================================
// morse_line_switch : per-channel registered Morse TX/RX router for GPIO pairs
//   with RX synchroniser, glitch filter (MORSE_LINE_FILTER_EN) and
//   break-before-make turnaround on every mode change.
// Revision 1.0
// ============================================================================
module morse_line_switch #(
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TURN_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] line_invert,
  input  logic [CHANNELS-1:0] line_loop,
  input  logic [CHANNELS-1:0] morse_code_out,
  output logic [CHANNELS-1:0] morse_code_in,
  output logic [CHANNELS-1:0] line_busy,
  inout  wire  [CHANNELS-1:0] GPIO0,
  inout  wire  [CHANNELS-1:0] GPIO1
);

  localparam int c_turn_w = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [c_turn_w-1:0] c_turn_last = c_turn_w'(TURN_CYCLES - 1);
`ifdef MORSE_LINE_FILTER_EN
  localparam int c_filt_w = $clog2(FILTER_LEN);
  localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILTER_LEN - 1);
`endif

  typedef enum logic [0:0] {
    ST_TURN   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    state_e                 state_q, state_d;
    logic [c_turn_w-1:0]    cnt_q, cnt_d;
    logic                   inv_q, inv_d, loop_q, loop_d;
    logic [1:0]             req_prev_q, req_prev_d;
    logic                   tx_q, tx_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_q, rx_d;
`ifdef MORSE_LINE_FILTER_EN
    logic [c_filt_w-1:0]    filt_q, filt_d;
`endif
    logic [1:0]             w_req;
    logic                   w_pin_rx;
    logic                   w_s;

    assign w_req    = {line_invert[ch], line_loop[ch]};
    // Synchroniser follows the latched mode, so it keeps watching the old RX pin during turnaround.
    assign w_pin_rx = inv_q ? GPIO1[ch] : GPIO0[ch];
    assign w_s      = sync_q[SYNC_STAGES-1];

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      inv_d      = inv_q;
      loop_d     = loop_q;
      req_prev_d = w_req;
      tx_d       = morse_code_out[ch];
      sync_d     = {sync_q[SYNC_STAGES-2:0], w_pin_rx};
      rx_d       = rx_q;
`ifdef MORSE_LINE_FILTER_EN
      filt_d     = filt_q;
`endif
      case (state_q)
        ST_TURN: begin
`ifdef MORSE_LINE_FILTER_EN
          filt_d = '0;
`endif
          if (w_req != req_prev_q) begin
            cnt_d = '0;
          end else if (cnt_q == c_turn_last) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
            inv_d   = w_req[1];
            loop_d  = w_req[0];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_req != {inv_q, loop_q}) begin
            state_d = ST_TURN;
            cnt_d   = '0;
          end
          if (loop_q) begin
            rx_d = morse_code_out[ch];
`ifdef MORSE_LINE_FILTER_EN
            filt_d = '0;
`endif
          end else begin
`ifdef MORSE_LINE_FILTER_EN
            if (w_s == rx_q) begin
              filt_d = '0;
            end else if (filt_q == c_filt_last) begin
              rx_d   = w_s;
              filt_d = '0;
            end else begin
              filt_d = filt_q + 1'b1;
            end
`else
            rx_d = w_s;
`endif
          end
        end
        default: state_d = ST_TURN;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= ST_TURN;
        cnt_q      <= '0;
        inv_q      <= 1'b0;
        loop_q     <= 1'b0;
        req_prev_q <= 2'b00;
        tx_q       <= 1'b0;
        sync_q     <= '0;
        rx_q       <= 1'b0;
`ifdef MORSE_LINE_FILTER_EN
        filt_q     <= '0;
`endif
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        inv_q      <= inv_d;
        loop_q     <= loop_d;
        req_prev_q <= req_prev_d;
        tx_q       <= tx_d;
        sync_q     <= sync_d;
        rx_q       <= rx_d;
`ifdef MORSE_LINE_FILTER_EN
        filt_q     <= filt_d;
`endif
      end
    end

    assign morse_code_in[ch] = rx_q;
    assign line_busy[ch]     = (state_q == ST_TURN);
    assign GPIO1[ch] = (state_q == ST_ACTIVE && !inv_q) ? tx_q : 1'bz;
    assign GPIO0[ch] = (state_q == ST_ACTIVE &&  inv_q) ? tx_q : 1'bz;
  end

endmodule
`default_nettype wire
